// File: rtl/cpu64_lsu_obi_driver_if.sv
// Bundle between the LSU-side OBI driver, the LSU stage and the OBI receiver shim.
// Latency: none; plain wires, all timing is owned by the driver.
// Backpressure: lsu_ready_o towards the LSU, gnt_i from the OBI side.
interface cpu64_lsu_obi_driver_if #(
  parameter int ADDR_W = 39,
  parameter int DATA_W = 64
);
  // LSU request / response
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic              lsu_we_i;
  logic [1:0]        lsu_size_i;
  logic              lsu_unsigned_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              resp_valid_o;
  logic              resp_err_o;
  logic [DATA_W-1:0] resp_rdata_o;
  // OBI host channel
  logic              req_o;
  logic              we_o;
  logic [7:0]        be_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              gnt_i;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;

  // Driver view
  modport master (
    input  lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    input  gnt_i, rvalid_i, rdata_i,
    output lsu_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
    output req_o, we_o, be_o, addr_o, wdata_o
  );

  // Environment view (LSU stage plus OBI receiver)
  modport slave (
    output lsu_valid_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    output gnt_i, rvalid_i, rdata_i,
    input  lsu_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
    input  req_o, we_o, be_o, addr_o, wdata_o
  );
endinterface

// File: rtl/cpu64_lsu_obi_driver.sv
// Core-side OBI host driver: one LSU load/store -> one OBI transaction, aligned/extended result back.
// Latency: store resp = grant + 1 cycle, load resp = rvalid + 1 cycle, misaligned err = accept + 1 cycle.
// Backpressure: lsu_ready_o only in IDLE (registered); OBI request held stable until gnt_i.
// Optional rvalid timeout with DRAIN state: define CPU64_LSU_TIMEOUT_EN.
module cpu64_lsu_obi_driver #(
  parameter int ADDR_W      = 39,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cpu64_lsu_obi_driver_if.master bus
);

  if (DATA_W != 64) begin : g_bad_data_w
    $error("cpu64_lsu_obi_driver: only DATA_W = 64 is supported");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("cpu64_lsu_obi_driver: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
`ifdef CPU64_LSU_TIMEOUT_EN
    WAIT_R = 2'd2,
    DRAIN  = 2'd3
`else
    WAIT_R = 2'd2
`endif
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ready;
  logic              w_accept;
  logic              w_misaligned;
  logic [7:0]        w_lane_mask;
  logic [7:0]        w_be_in;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_load_ext;
  logic              w_in_req;

  // captured request fields
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [2:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_be;
  logic [DATA_W-1:0] r_wdata;

  // registered response
  logic              r_resp_vld;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              w_resp_vld_nxt;
  logic              w_resp_err_nxt;
  logic [DATA_W-1:0] w_resp_rdata_nxt;
  logic              w_timeout;

`ifdef CPU64_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  // WAIT_R cycle counter; sits at zero outside WAIT_R so it is clear on entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state != WAIT_R) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // last WAIT_R cycle: the counter would reach TIMEOUT_CYC on this edge
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // natural-alignment check on the incoming request
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.lsu_size_i)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = bus.lsu_addr_i[0];
      2'd2:    w_misaligned = |bus.lsu_addr_i[1:0];
      default: w_misaligned = |bus.lsu_addr_i[2:0];
    endcase
  end

  // lane mask and size-width store data replicated over every lane
  always_comb begin
    w_lane_mask = 8'h01;
    w_wdata_rep = bus.lsu_wdata_i;
    case (bus.lsu_size_i)
      2'd0: begin
        w_lane_mask = 8'h01;
        w_wdata_rep = {8{bus.lsu_wdata_i[7:0]}};
      end
      2'd1: begin
        w_lane_mask = 8'h03;
        w_wdata_rep = {4{bus.lsu_wdata_i[15:0]}};
      end
      2'd2: begin
        w_lane_mask = 8'h0F;
        w_wdata_rep = {2{bus.lsu_wdata_i[31:0]}};
      end
      default: begin
        w_lane_mask = 8'hFF;
        w_wdata_rep = bus.lsu_wdata_i;
      end
    endcase
  end

  assign w_be_in  = w_lane_mask << bus.lsu_addr_i[2:0];
  assign w_rshift = bus.rdata_i >> {r_lo, 3'b000};

  // right-justify the addressed lanes and extend to 64 bits
  always_comb begin
    w_load_ext = w_rshift;
    case (r_size)
      2'd0:    w_load_ext = r_uns ? {56'd0, w_rshift[7:0]}  : {{56{w_rshift[7]}},  w_rshift[7:0]};
      2'd1:    w_load_ext = r_uns ? {48'd0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
      2'd2:    w_load_ext = r_uns ? {32'd0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  // next state and next response
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_resp_vld_nxt   = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;
    case (r_state)
      IDLE: begin
        if (r_ready && bus.lsu_valid_i) begin
          w_accept = 1'b1;
          if (w_misaligned) begin
            w_resp_vld_nxt = 1'b1;
            w_resp_err_nxt = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (bus.gnt_i) begin
          if (r_we) begin
            w_resp_vld_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (bus.rvalid_i) begin
          w_resp_vld_nxt   = 1'b1;
          w_resp_rdata_nxt = w_load_ext;
          w_state_nxt      = IDLE;
        end else if (w_timeout) begin
          w_resp_vld_nxt = 1'b1;
          w_resp_err_nxt = 1'b1;
`ifdef CPU64_LSU_TIMEOUT_EN
          w_state_nxt    = DRAIN;
`endif
        end
      end
`ifdef CPU64_LSU_TIMEOUT_EN
      DRAIN: begin
        // the late response belongs to an already-failed access; drop it
        if (bus.rvalid_i) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register; ready is cleared by reset and follows the next state, so it never sees gnt_i combinationally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  // one-cycle response pulse; err/rdata are zero whenever the pulse is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_vld   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_vld   <= w_resp_vld_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
    end
  end

  // capture the request so the OBI fields stay frozen until granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_lo    <= 3'd0;
      r_addr  <= '0;
      r_be    <= 8'h00;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.lsu_we_i;
      r_size  <= bus.lsu_size_i;
      r_uns   <= bus.lsu_unsigned_i;
      r_lo    <= bus.lsu_addr_i[2:0];
      r_addr  <= {bus.lsu_addr_i[ADDR_W-1:3], 3'b000};
      r_be    <= w_be_in;
      r_wdata <= w_wdata_rep;
    end
  end

  assign w_in_req         = (r_state == REQ);
  assign bus.lsu_ready_o  = r_ready;
  assign bus.req_o        = w_in_req;
  assign bus.we_o         = w_in_req & r_we;
  assign bus.be_o         = w_in_req ? r_be    : 8'h00;
  assign bus.addr_o       = w_in_req ? r_addr  : '0;
  assign bus.wdata_o      = w_in_req ? r_wdata : '0;
  assign bus.resp_valid_o = r_resp_vld;
  assign bus.resp_err_o   = r_resp_err;
  assign bus.resp_rdata_o = r_resp_rdata;

endmodule
